// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA display path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vga_pkg;

  // Framebuffer writer control states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    UNPACK  = 2'd2,
    WAIT_VS = 2'd3
  } fbw_state_t;

  localparam int BYTES_PER_BLOCK    = 16;
  localparam int AES_BLOCK_W        = 128;
  localparam int DEFAULT_NUM_PIXELS = 65536;

endpackage

// File: rtl/edge_detect_fall.sv
// 1-bit falling-edge detector: registers the previous sample, flags 1 -> 0.
// Latency: fall is combinational from the current input and the registered previous sample.
// Backpressure: none.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   d    - input level, already synchronous to clk
//   fall - high while previous sample was 1 and current input is 0
module edge_detect_fall (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic fall
);

  logic d_q;

  // Reset to 0 so that a low level right after reset is not mistaken for an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign fall = d_q & ~d;

endmodule

// File: rtl/fb_writer.sv
// Unpacks 128-bit AES blocks into 16 pixel bytes and writes them to the back bank; swaps banks on vsync fall.
// Latency: byte 0 is written the cycle after a beat is accepted; bytes 1..15 follow back to back.
// Backpressure: in_ready is high only in LOAD, so one beat per 17 cycles at most; start outside IDLE is ignored.
//
// Ports:
//   clk, rst              - clock and synchronous active-low reset
//   start                 - pulse that begins a new frame (honoured only in IDLE)
//   in_valid/in_ready     - input handshake for in_data (byte 0 = in_data[127:120])
//   vsync                 - active-low vertical sync, synchronous to clk
//   we/waddr/wdata        - registered pixel RAM write port
//   wbank/disp_bank       - bank being written / bank being displayed (always complementary)
//   busy                  - high outside IDLE
//   frame_done            - one-cycle pulse on each bank swap
module fb_writer
  import vga_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int NUM_PIXELS = DEFAULT_NUM_PIXELS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  input  logic                   vsync,
  output logic                   we,
  output logic [ADDR_W-1:0]      waddr,
  output logic [7:0]             wdata,
  output logic                   wbank,
  output logic                   disp_bank,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int IDX_W = $clog2(BYTES_PER_BLOCK);
  // pix is one bit wider than waddr so a full 2^ADDR_W frame count is representable.
  localparam logic [ADDR_W:0]  PIX_END   = (ADDR_W + 1)'(NUM_PIXELS);
  localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(BYTES_PER_BLOCK - 1);

  fbw_state_t             state;
  fbw_state_t             state_nxt;
  logic [ADDR_W:0]        pix;
  logic [IDX_W-1:0]       byte_idx;
  logic [AES_BLOCK_W-1:0] shreg;
  logic                   vs_fall;
  logic                   accept;
  logic                   unpack_more;

  edge_detect_fall u_vs_fall (
    .clk  (clk),
    .rst  (rst),
    .d    (vsync),
    .fall (vs_fall)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state. byte_idx is the index of the byte currently on wdata, so
  // UNPACK spans exactly the 16 cycles in which a beat's bytes are presented.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    unpack_more = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = UNPACK;
        end
      end
      UNPACK: begin
        // Frame end wins: remaining bytes of the final beat are dropped.
        if (pix == PIX_END) begin
          state_nxt = WAIT_VS;
        end else if (byte_idx == LAST_BYTE) begin
          state_nxt = LOAD;
        end else begin
          unpack_more = 1'b1;
        end
      end
      WAIT_VS: begin
        if (vs_fall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: shift register, pixel counter, registered write port, bank.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pix        <= '0;
      byte_idx   <= '0;
      shreg      <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      disp_bank  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;

      if (state == IDLE && start) begin
        pix <= '0;
      end

      // Byte 0 goes straight from in_data to the write port; the shift
      // register keeps the remaining 15 bytes at its top.
      if (accept) begin
        shreg    <= {in_data[AES_BLOCK_W-9:0], 8'h00};
        byte_idx <= '0;
        we       <= 1'b1;
        waddr    <= pix[ADDR_W-1:0];
        wdata    <= in_data[AES_BLOCK_W-1 -: 8];
        pix      <= pix + 1'b1;
      end else if (unpack_more) begin
        shreg    <= {shreg[AES_BLOCK_W-9:0], 8'h00};
        byte_idx <= byte_idx + 1'b1;
        we       <= 1'b1;
        waddr    <= pix[ADDR_W-1:0];
        wdata    <= shreg[AES_BLOCK_W-1 -: 8];
        pix      <= pix + 1'b1;
      end

      if (state == WAIT_VS && vs_fall) begin
        disp_bank  <= ~disp_bank;
        frame_done <= 1'b1;
      end
    end
  end

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign wbank    = ~disp_bank;

endmodule

// File: doc/fb_writer.md
# fb_writer

Framebuffer writer for the pipeline's VGA display path. It accepts 128-bit AES result blocks from the SIMD pipeline, unpacks each into 16 pixel bytes, and writes them into the back bank of the double-buffered pixel RAM that `vga_ram_block` scans out. When a full frame is written, it swaps banks on the next vertical-sync falling edge, so the display never shows a partially written image.

## Interface
Parameters:
- `ADDR_W`, default 16: pixel address width.
- `NUM_PIXELS`, default 65536: pixels per frame, in the range 1..2^ADDR_W.

Ports:
- `clk` input 1: single system clock; every register is clocked on the rising edge.
- `rst` input 1: reset, synchronous and active-low.
- `start` input 1: one-cycle pulse that begins writing a new frame.
- `in_valid` input 1: an input block is offered.
- `in_ready` output 1: the block accepts an input beat.
- `in_data` input 128: AES block; byte 0 is `in_data[127:120]`.
- `vsync` input 1: VGA vertical sync, active-low, synchronous to `clk`.
- `we` output 1: pixel RAM write enable.
- `waddr` output ADDR_W: pixel write address.
- `wdata` output 8: pixel byte.
- `wbank` output 1: bank being written; always equals `~disp_bank`.
- `disp_bank` output 1: bank being displayed; drives the `switch` input of `vga_ram_block`.
- `busy` output 1: high in every state except IDLE.
- `frame_done` output 1: one-cycle pulse on each bank swap.

## Operation
- State machine states: IDLE, LOAD, UNPACK, WAIT_VS.
- IDLE:
  - `start` -> LOAD; pixel counter `pix` = 0.
  - All other inputs are ignored.
- LOAD:
  - `in_ready` = 1 only in this state.
  - A beat is accepted when `in_valid & in_ready`; it is latched into a shift register, the byte index is set to 0, and the state moves to UNPACK.
- UNPACK: one byte is written per cycle.
  - `wdata` = shift register [127:120]; `waddr` = `pix`; `we` = 1.
  - Each cycle: shift left by 8, `pix`++.
  - After byte 15 -> LOAD.
  - The write of pixel `NUM_PIXELS-1` ends the frame: -> WAIT_VS. Leftover bytes of that beat are dropped with `we` = 0; no wrap into address 0.
- WAIT_VS:
  - Registered `vsync` edge detect. A falling edge (previous 1, current 0) toggles `disp_bank`, pulses `frame_done` and returns to IDLE.
  - If `vsync` is already low on entry, the block waits for the next falling edge.
- `start` asserted in any state other than IDLE is ignored; there is no queuing.
- Width rules:
  - `pix` is ADDR_W+1 bits wide so that `NUM_PIXELS` = 2^ADDR_W is representable.
  - `waddr` = `pix[ADDR_W-1:0]`.

## Timing
- Reset values:
  - state IDLE.
  - `we`, `in_ready`, `busy`, `frame_done` = 0.
  - `waddr` = 0, `wdata` = 0, `disp_bank` = 0, `wbank` = 1.
- Reset mid-frame aborts immediately.
  - `disp_bank` returns to 0.
  - The partially written bank is not swapped in.
- `we`, `waddr`, `wdata` are registered outputs.
- Latency: a beat accepted at edge n produces byte 0 with `we` = 1 in the cycle after edge n. Bytes 1..15 follow in consecutive cycles.
- Handshake rules:
  - `in_ready` drops the cycle after acceptance and reasserts in the cycle after byte 15.
  - With `in_valid` held high, sustained throughput is 16 pixels per 17 cycles.
  - `in_data` is sampled only on an accepted beat.
- `frame_done` is high for the single cycle after the detected `vsync` edge. `disp_bank` and `wbank` change on the same edge.
- Simultaneous `start` and a `vsync` edge in WAIT_VS: the swap happens and `start` is ignored.
- `vsync` is already synchronous to `clk` (it comes from `vga_ram_block`), so no synchronizer is needed.

## Structure
- Shared package `vga_pkg`:
  - state enum `fbw_state_t`.
  - `BYTES_PER_BLOCK` = 16.
  - `AES_BLOCK_W` = 128.
  - the default pixel count.
- Optional sub-module `edge_detect_fall` (1-bit registered falling-edge detector), reusable by `vga_ram_block` consumers.
- Everything else is inline: FSM, shift register, pixel counter and bank register.

## Test plan
- Reset behaviour: hold `rst` = 0 for 3 cycles with `in_valid` = 1 -> all outputs at their reset values; `in_ready` = 0.
- Single beat: with `NUM_PIXELS` = 32, `start`, then one beat `in_data` = 0x00112233_44556677_8899AABB_CCDDEEFF.
  - Required: 16 consecutive writes, `waddr` 0..15, `wdata` 0x00, 0x11, ..., 0xFF, `wbank` = 1.
  - `in_ready` is low during those 16 cycles.
- Partial last beat: `NUM_PIXELS` = 20, two beats.
  - Required: exactly 20 writes (addresses 0..19); the last 12 bytes of beat 2 are not written; state WAIT_VS.
- Bank swap: complete a frame with `vsync` = 1 for 50 cycles, then 0.
  - Required: no swap while `vsync` is high.
  - One cycle after the falling edge: `disp_bank` 0->1, `frame_done` pulses once, `wbank` = 0.
  - A second frame swaps back to `disp_bank` = 0.
- Backpressure and ignored start: drop `in_valid` for 5 cycles between beats and pulse `start` mid-UNPACK.
  - Required: `in_ready` stays high while waiting; addresses stay contiguous; the `start` pulse has no effect.
- Reset mid-frame: assert `rst` = 0 at pixel 7 of frame 2 (`disp_bank` = 1).
  - Required: `we` = 0 the next cycle; `disp_bank` = 0; state IDLE; the following `start` restarts at `waddr` = 0.
